reg_file_mwp: RTL

- Parametrised multi-write-port, multi-read-port register file.
- Successor to the 2-entry, 1-write-port register file.
- Adds per-port byte enables, deterministic write-port priority, synchronous clear and registered read ports with write-first forwarding.
- Also provides per-entry valid bits, a write-conflict flag and the flat all-register output.
- Sits between the datapath write-back stages and consumers that read either a few addressed entries or the whole file.

---
 rtl/reg_file_mwp.sv | 118 +++++++++++
 1 files changed

// File: rtl/reg_file_mwp.sv
// Multi-write-port, multi-read-port register file with per-byte enables,
// highest-port-wins write priority, synchronous clear and write-first registered reads.
module reg_file_mwp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int NWP   = 2,
  parameter int NRP   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NWP-1:0]           wen_in,
  input  logic [NWP*AW-1:0]        waddr_in,
  input  logic [NWP*WIDTH-1:0]     d_in,
  input  logic [NWP*(WIDTH/8)-1:0] be_in,
  input  logic                     clr_in,
  input  logic [NRP*AW-1:0]        raddr_in,
  output logic [NRP*WIDTH-1:0]     rd_out,
  output logic [DEPTH*WIDTH-1:0]   a_out,
  output logic [DEPTH-1:0]         valid_out,
  output logic                     conflict_out
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0]     mem_reg  [DEPTH];
  logic [WIDTH-1:0]     mem_next [DEPTH];
  logic [DEPTH-1:0]     valid_reg, valid_next;
  logic [NRP*WIDTH-1:0] rd_reg, rd_next;
  logic                 conflict_reg, conflict_next;

  // Ports are visited in ascending order, so the highest qualifying port
  // overwrites each byte last. Out-of-range addresses never match an entry.
  always_comb begin
    valid_next = valid_reg;
    for (int e = 0; e < DEPTH; e++) begin
      mem_next[e] = mem_reg[e];
      for (int p = 0; p < NWP; p++) begin
        for (int b = 0; b < NB; b++) begin
          if (wen_in[p] && (waddr_in[p*AW +: AW] == AW'(e)) && be_in[p*NB + b]) begin
            mem_next[e][b*8 +: 8] = d_in[p*WIDTH + b*8 +: 8];
            valid_next[e]         = 1'b1;
          end
        end
      end
    end
    if (clr_in) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_next[e] = '0;
      end
      valid_next = '0;
    end
  end

  // A conflict needs two enabled ports on the same in-range entry with
  // at least one shared byte lane.
  always_comb begin
    conflict_next = 1'b0;
    for (int p = 0; p < NWP; p++) begin
      for (int q = p + 1; q < NWP; q++) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (wen_in[p] && wen_in[q]
              && (waddr_in[p*AW +: AW] == AW'(e))
              && (waddr_in[q*AW +: AW] == AW'(e))
              && (|(be_in[p*NB +: NB] & be_in[q*NB +: NB]))) begin
            conflict_next = 1'b1;
          end
        end
      end
    end
    if (clr_in) begin
      conflict_next = 1'b0;
    end
  end

  // Reads sample the post-update contents, giving write-first forwarding.
  always_comb begin
    rd_next = '0;
    for (int r = 0; r < NRP; r++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (raddr_in[r*AW +: AW] == AW'(e)) begin
          rd_next[r*WIDTH +: WIDTH] = mem_next[e];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_reg[e] <= '0;
      end
      valid_reg    <= '0;
      rd_reg       <= '0;
      conflict_reg <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_reg[e] <= mem_next[e];
      end
      valid_reg    <= valid_next;
      rd_reg       <= rd_next;
      conflict_reg <= conflict_next;
    end
  end

  // Entry 0 lands in the most significant slice of the flat view.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign a_out[WIDTH*(DEPTH-1-gi) +: WIDTH] = mem_reg[gi];
    end
  endgenerate

  assign rd_out       = rd_reg;
  assign valid_out    = valid_reg;
  assign conflict_out = conflict_reg;

endmodule
